star_rating_anim: RTL and testbench

- Parametrised successor to the end-of-level star score overlay.
- Renders NUM_STARS star sprites in a row and reveals the earned stars one at a time, paced by the frame tick. Earned stars = number of coins collected.
- Sits between game logic (CoinStatus, start/clear) and the colour mapper; drives an external synchronous star ROM.
- is_star and is_lit feed the colour mapper's priority mux.

---
 rtl/star_rating_anim.sv | 233 +++++++++++++++++++++++
 tb/tb_star_rating_anim.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_rating_anim.sv
// star_rating_anim: end-of-level star score overlay.
// Draws NUM_STARS star sprites in a row and reveals the earned stars one at a
// time, paced by frame_tick. Earned stars = number of coins collected
// (CoinStatus bit = 0). Drives an external synchronous star ROM holding a dim
// sprite in rows [0, STAR_H) and a lit sprite in rows [STAR_H, 2*STAR_H).
// The pixel outputs is_star / is_lit trail DrawX / DrawY by two clocks.
//
// Optional build macro STAR_RATING_TWINKLE_EN: when defined, a 5-bit counter
// runs on frame_tick in DONE and one lit star blinks dim while counter[2] = 1.
// When undefined, DONE shows all earned stars lit and steady.
module star_rating_anim #(
  parameter int NUM_STARS     = 3,
  parameter int STAR_W        = 130,
  parameter int STAR_H        = 130,
  parameter int STAR_X0       = 80,
  parameter int STAR_PITCH    = 170,
  parameter int STAR_Y0       = 140,
  parameter int CENTER_RAISE  = 50,
  parameter int REVEAL_FRAMES = 30,
  parameter int ADDR_W        = $clog2(2*STAR_H)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic                 clear,
  input  logic [NUM_STARS-1:0] CoinStatus,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [STAR_W-1:0]    rom_data,
  output logic                 is_star,
  output logic                 is_lit,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           earned
);

  localparam int CNT_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam int COL_W = (STAR_W > 1) ? $clog2(STAR_W) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(REVEAL_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REVEAL = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state;
  logic               armed;      // start accepted, outcome decided next cycle
  logic [CNT_W-1:0]   frame_cnt;
  logic [2:0]         shown;      // stars currently revealed as lit

  logic [NUM_STARS-1:0] lit_vec;
  logic                 hit;
  logic                 hit_lit;
  logic [ADDR_W-1:0]    row;
  logic [COL_W-1:0]     col;

  logic                 hit_p1;
  logic                 lit_p1;
  logic [COL_W-1:0]     col_p1;

  // Number of collected coins (CoinStatus bit clear) -> earned stars.
  function automatic logic [2:0] coins_taken(input logic [NUM_STARS-1:0] status);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_STARS; i++) begin
      if (!status[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Left X of star i, in the 11-bit space used for all bounds checks.
  function automatic logic [10:0] star_x(input int i);
    return 11'(STAR_X0 + i * STAR_PITCH);
  endfunction

  // Top Y of star i: inner stars sit CENTER_RAISE rows higher than the outer two.
  function automatic logic [10:0] star_y(input int i);
    if (i > 0 && i < NUM_STARS - 1) return 11'(STAR_Y0 - CENTER_RAISE);
    else                             return 11'(STAR_Y0);
  endfunction

  // True when the 11-bit pixel position lies inside the box of star i.
  function automatic logic in_box(input int i, input logic [10:0] x, input logic [10:0] y);
    return (x >= star_x(i)) && (x < star_x(i) + 11'(STAR_W)) &&
           (y >= star_y(i)) && (y < star_y(i) + 11'(STAR_H));
  endfunction

  // Reveal sequencer: IDLE -> (one decision cycle) -> REVEAL or DONE, clear back to IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      frame_cnt <= '0;
      shown     <= 3'd0;
      earned    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            armed <= 1'b0;
          end else if (armed) begin
            armed <= 1'b0;
            if (earned == 3'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_REVEAL;
              busy  <= 1'b1;
            end
          end else if (start) begin
            earned    <= coins_taken(CoinStatus);
            frame_cnt <= '0;
            shown     <= 3'd0;
            armed     <= 1'b1;
          end
        end
        S_REVEAL: begin
          if (clear) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            shown     <= 3'd0;
            frame_cnt <= '0;
          end else if (frame_tick) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt <= '0;
              shown     <= shown + 3'd1;
              if (shown + 3'd1 == earned) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (clear) begin
            state <= S_IDLE;
            done  <= 1'b0;
            shown <= 3'd0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STAR_RATING_TWINKLE_EN
  logic [4:0] twk_cnt;
  logic [2:0] twk_idx;

  // Twinkle phase counter: runs on frame ticks only while the reveal is complete.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      twk_cnt <= 5'd0;
    end else if (state != S_DONE) begin
      twk_cnt <= 5'd0;
    end else if (frame_tick) begin
      twk_cnt <= twk_cnt + 5'd1;
    end
  end

  assign twk_idx = (earned == 3'd0) ? 3'd0 : ({1'b0, twk_cnt[4:3]} % earned);
`endif

  // Per-star lit flags: the first `shown` stars are lit.
  always_comb begin
    lit_vec = '0;
    for (int i = 0; i < NUM_STARS; i++) begin
      lit_vec[i] = (3'(i) < shown);
`ifdef STAR_RATING_TWINKLE_EN
      if (state == S_DONE && twk_cnt[2] && 3'(i) == twk_idx) lit_vec[i] = 1'b0;
`endif
    end
  end

  // Box hit test; scanning from the top index down lets the lowest index win overlaps.
  always_comb begin
    hit     = 1'b0;
    hit_lit = 1'b0;
    row     = '0;
    col     = '0;
    for (int i = NUM_STARS - 1; i >= 0; i--) begin
      if (in_box(i, {1'b0, DrawX}, {1'b0, DrawY})) begin
        hit     = 1'b1;
        hit_lit = lit_vec[i];
        row     = ADDR_W'({1'b0, DrawY} - star_y(i));
        col     = COL_W'({1'b0, DrawX} - star_x(i));
      end
    end
  end

  // ROM row select: lit sprite lives STAR_H rows above the dim one.
  always_comb begin
    rom_addr = '0;
    if (hit) rom_addr = hit_lit ? (ADDR_W'(STAR_H) + row) : row;
  end

  // Stage p1: hold hit, column and lit flag while the ROM fetches the row.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_p1 <= 1'b0;
      lit_p1 <= 1'b0;
      col_p1 <= '0;
    end else begin
      hit_p1 <= hit;
      lit_p1 <= hit_lit;
      col_p1 <= col;
    end
  end

  // Stage p2: pick the pixel bit out of the returned ROM row.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_star <= 1'b0;
      is_lit  <= 1'b0;
    end else begin
      is_star <= hit_p1 & rom_data[col_p1];
      is_lit  <= lit_p1 & hit_p1;
    end
  end

endmodule

// File: tb/tb_star_rating_anim.sv
// Testbench for star_rating_anim (default build, twinkle disabled).
// Control outputs are compared against a reveal model after every action;
// pixel expectations are queued at drive time and popped by a monitor when
// the two-cycle pipeline delivers them.
module tb_star_rating_anim;

  localparam int NS    = 3;
  localparam int W     = 130;
  localparam int H     = 130;
  localparam int X0    = 80;
  localparam int PITCH = 170;
  localparam int Y0    = 140;
  localparam int RAISE = 50;
  localparam int RF    = 2;
  localparam int AW    = 9;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [NS-1:0] CoinStatus = '1;
  logic [9:0]    DrawX = '0;
  logic [9:0]    DrawY = '0;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data = '0;
  logic          is_star, is_lit, busy, done;
  logic [2:0]    earned;

  star_rating_anim #(
    .NUM_STARS(NS), .STAR_W(W), .STAR_H(H), .STAR_X0(X0), .STAR_PITCH(PITCH),
    .STAR_Y0(Y0), .CENTER_RAISE(RAISE), .REVEAL_FRAMES(RF), .ADDR_W(AW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .clear(clear),
    .CoinStatus(CoinStatus), .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
    .rom_data(rom_data), .is_star(is_star), .is_lit(is_lit), .busy(busy),
    .done(done), .earned(earned)
  );

  always #10 Clk = ~Clk;

  // Synchronous star ROM model.
  logic [W-1:0] rom_mem [0:511];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the reveal.
  int phase    = 0;   // 0 idle, 1 revealing, 2 complete
  int m_earned = 0;
  int m_shown  = 0;
  int m_ticks  = 0;

  // Pixel scoreboard.
  logic [1:0] exp_q[$];
  logic       pix_vld = 1'b0;
  logic       pv1 = 1'b0, pv2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge Clk) begin
    pv1 <= pix_vld;
    pv2 <= pv1;
  end

  logic [1:0] e;
  always @(negedge Clk) begin
    if (pv2) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pix_queue: output presented with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        check("is_star", 32'(is_star), 32'(e[1]));
        check("is_lit",  32'(is_lit),  32'(e[0]));
      end
    end
  end

  function automatic int sx(input int i);
    return X0 + i * PITCH;
  endfunction

  function automatic int sy(input int i);
    return (i >= 1 && i <= NS - 2) ? Y0 - RAISE : Y0;
  endfunction

  function automatic int star_of(input int x, input int y);
    for (int i = 0; i < NS; i++)
      if (x >= sx(i) && x < sx(i) + W && y >= sy(i) && y < sy(i) + H) return i;
    return -1;
  endfunction

  function automatic int collected(input logic [NS-1:0] c);
    int n = 0;
    for (int i = 0; i < NS; i++) if (c[i] == 1'b0) n++;
    return n;
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, ".busy"},   32'(busy),   32'(phase == 1));
    check({tag, ".done"},   32'(done),   32'(phase == 2));
    check({tag, ".earned"}, 32'(earned), 32'(m_earned));
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    if (phase == 1) begin
      m_ticks++;
      m_shown = m_ticks / RF;
      if (m_shown >= m_earned) begin
        m_shown = m_earned;
        phase   = 2;
      end
    end
    check_ctrl("tick");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    phase   = 0;
    m_shown = 0;
    check_ctrl("clear");
  endtask

  task automatic do_start(input logic [NS-1:0] c, input bit with_clear);
    bit pend;
    pend = 1'b0;
    CoinStatus = c;
    start = 1'b1;
    clear = with_clear;
    cyc();
    start = 1'b0;
    clear = 1'b0;
    if (with_clear) begin
      phase   = 0;
      m_shown = 0;
    end else if (phase == 0) begin
      m_earned = collected(c);
      m_ticks  = 0;
      m_shown  = 0;
      pend     = 1'b1;
    end
    check_ctrl("start_c1");
    CoinStatus = NS'($urandom);
    cyc();
    if (pend) phase = (m_earned == 0) ? 2 : 1;
    check_ctrl("start_c2");
  endtask

  task automatic drive_pixel(input int x, input int y);
    int s, addr, lit, st;
    s = star_of(x, y);
    addr = 0; lit = 0; st = 0;
    if (s >= 0) begin
      lit  = (s < m_shown) ? 1 : 0;
      addr = (lit != 0 ? H : 0) + (y - sy(s));
      st   = int'(rom_mem[addr][x - sx(s)]);
    end
    DrawX   = 10'(x);
    DrawY   = 10'(y);
    pix_vld = 1'b1;
    exp_q.push_back({st[0], lit[0]});
    @(negedge Clk);
    check("rom_addr", 32'(rom_addr), 32'(addr));
    @(posedge Clk);
    #1;
  endtask

  task automatic pixel_end();
    pix_vld = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic sweep_centres();
    for (int i = 0; i < NS; i++) drive_pixel(sx(i) + 20, sy(i) + 10);
    pixel_end();
  endtask

  task automatic random_pixels(input int n);
    int i, x, y;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end else begin
        i = $urandom_range(0, NS - 1);
        x = sx(i) + $urandom_range(0, W + 3) - 2;
        y = sy(i) + $urandom_range(0, H + 3) - 2;
      end
      drive_pixel(x, y);
    end
    pixel_end();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] tmp;
    for (int a = 0; a < 512; a++) begin
      tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rom_mem[a] = tmp[W-1:0];
    end
    rom_mem[H][0] = 1'b1;   // lit row 0, leftmost pixel opaque

    // Reset state while reset is held.
    #35;
    check("rst.busy",    32'(busy),    32'd0);
    check("rst.done",    32'(done),    32'd0);
    check("rst.earned",  32'(earned),  32'd0);
    check("rst.is_star", 32'(is_star), 32'd0);
    check("rst.is_lit",  32'(is_lit),  32'd0);
    cyc();
    Reset = 1'b0;
    cyc();

    // Reset in the middle of a reveal.
    do_start(3'b000, 1'b0);
    repeat (3) do_tick();
    drive_pixel(X0, Y0);
    pixel_end();
    Reset = 1'b1;
    #3;
    phase = 0; m_earned = 0; m_shown = 0; m_ticks = 0;
    check_ctrl("async_rst");
    cyc();
    Reset = 1'b0;
    cyc();
    sweep_centres();

    // Full reveal of two stars.
    do_start(3'b010, 1'b0);
    repeat (2) do_tick();
    sweep_centres();
    repeat (2) do_tick();
    drive_pixel(80, 140);
    drive_pixel(79, 140);
    drive_pixel(250, 90);
    drive_pixel(250, 89);
    drive_pixel(430, 150);
    pixel_end();

    // Start ignored while busy.
    do_clear();
    do_start(3'b011, 1'b0);
    do_start(3'b000, 1'b0);
    repeat (2) do_tick();

    // clear and start together in DONE: clear wins.
    do_start(3'b000, 1'b1);
    drive_pixel(250, 90);
    pixel_end();

    // Zero coins collected.
    do_start(3'b111, 1'b0);
    sweep_centres();
    do_clear();

    // Randomised mix of control actions and pixel bursts.
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 5))
        0: do_start(NS'($urandom), 1'b0);
        1: repeat ($urandom_range(1, 4)) do_tick();
        2: do_clear();
        3: random_pixels(6);
        4: do_start(NS'($urandom), 1'b1);
        default: begin
          do_start(NS'($urandom), 1'b0);
          repeat ($urandom_range(1, 7)) do_tick();
          random_pixels(4);
        end
      endcase
    end

    repeat (3) cyc();
    check("pix_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
